// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: read side of the async FIFO; owns the read pointer, empty/level flags, the RAM read port and a 2-deep output queue.
module fifo_rd_ctrl #(
    parameter int ASIZE = 4,
    parameter int DSIZE = 8
) (
    input  logic             sync_clk,
    input  logic             sync_rst,
    input  logic [ASIZE:0]   rq2_wptr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE-1:0] raddr,
    output logic             ren,
    input  logic [DSIZE-1:0] rdata_mem,
    output logic [DSIZE-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             rempty,
    output logic [ASIZE:0]   rlevel
);
    logic [ASIZE:0]   rbin, rbin_nx, rgray_nx, wbin;
    logic             inflight, pop;
    logic [1:0]       qcnt, qcnt_pop;
    logic [2:0]       need;
    logic [DSIZE-1:0] slot1, head_pop;

    always_comb begin
        wbin = rq2_wptr;
        for (int i = ASIZE - 1; i >= 0; i--) wbin[i] = wbin[i+1] ^ rq2_wptr[i];
    end

    assign pop       = out_valid & out_ready;
    assign need      = {1'b0, qcnt} + {2'b0, inflight} - {2'b0, pop};
    assign ren       = !rempty && need < 3'd2;
    assign rbin_nx   = rbin + {{ASIZE{1'b0}}, ren};
    assign rgray_nx  = rbin_nx ^ (rbin_nx >> 1);
    assign raddr     = rbin[ASIZE-1:0];
    assign out_valid = qcnt != 2'd0;
    assign qcnt_pop  = qcnt - {1'b0, pop};
    assign head_pop  = pop ? slot1 : out_data;

    always_ff @(posedge sync_clk or negedge sync_rst)
        if (!sync_rst) begin
            rbin     <= '0;
            rptr     <= '0;
            rempty   <= 1'b1;
            rlevel   <= '0;
            inflight <= 1'b0;
            qcnt     <= 2'd0;
            out_data <= '0;
            slot1    <= '0;
        end else begin
            rbin     <= rbin_nx;
            rptr     <= rgray_nx;
            rempty   <= rgray_nx == rq2_wptr;
            rlevel   <= wbin - rbin_nx;
            inflight <= ren;
            qcnt     <= qcnt_pop + {1'b0, inflight};
            out_data <= (inflight && qcnt_pop == 2'd0) ? rdata_mem : head_pop;
            slot1    <= (inflight && qcnt_pop != 2'd0) ? rdata_mem : slot1;
        end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: vector table plus directed sequences for the FIFO read controller at ASIZE=4 and ASIZE=2.
module tb_fifo_rd_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    function automatic int gray(int b);
        return b ^ (b >> 1);
    endfunction

    int total = 0;
    int bad = 0;

    task automatic chk(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int         wb4 = 0;
    logic       rdy4 = 1'b0;
    logic [4:0] wptr4, rptr4, rl4;
    logic [3:0] raddr4;
    logic       ren4, ov4, rempty4;
    logic [7:0] rdata4 = '0, od4;
    logic [7:0] mem4 [16];
    assign wptr4 = 5'(gray(wb4 % 32));

    int         wb2 = 0;
    logic       rdy2 = 1'b0;
    logic [2:0] wptr2, rptr2, rl2;
    logic [1:0] raddr2;
    logic       ren2, ov2, rempty2;
    logic [7:0] rdata2 = '0, od2;
    logic [7:0] mem2 [4];
    assign wptr2 = 3'(gray(wb2 % 8));

    fifo_rd_ctrl #(.ASIZE(4), .DSIZE(8)) dut4 (
        .sync_clk(clk), .sync_rst(rst), .rq2_wptr(wptr4), .rptr(rptr4), .raddr(raddr4),
        .ren(ren4), .rdata_mem(rdata4), .out_data(od4), .out_valid(ov4),
        .out_ready(rdy4), .rempty(rempty4), .rlevel(rl4)
    );

    fifo_rd_ctrl #(.ASIZE(2), .DSIZE(8)) dut2 (
        .sync_clk(clk), .sync_rst(rst), .rq2_wptr(wptr2), .rptr(rptr2), .raddr(raddr2),
        .ren(ren2), .rdata_mem(rdata2), .out_data(od2), .out_valid(ov2),
        .out_ready(rdy2), .rempty(rempty2), .rlevel(rl2)
    );

    // RAM models with one cycle read latency
    always @(posedge clk) begin
        if (ren4) rdata4 <= mem4[raddr4];
        if (ren2) rdata2 <= mem2[raddr2];
    end

    typedef struct {
        int wb; int rdy; int ren; int raddr; int rempty; int ov; int od; int rl; int rptr;
    } vec_t;
    vec_t tv [17];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int nren, nbeat, first_ren, first_beat;
        // wb, rdy | ren, raddr, rempty, ov, od, rl, rptr
        tv[0]  = '{0, 1, 0, 0, 1, 0, 'h00, 0, 0};
        tv[1]  = '{1, 1, 0, 0, 1, 0, 'h00, 0, 0};
        tv[2]  = '{1, 1, 1, 0, 0, 0, 'h00, 1, 0};
        tv[3]  = '{1, 1, 0, 0, 1, 0, 'h00, 0, 1};
        tv[4]  = '{1, 1, 0, 0, 1, 1, 'hA5, 0, 1};
        tv[5]  = '{6, 0, 0, 0, 1, 0, 'h00, 0, 1};
        tv[6]  = '{6, 0, 1, 1, 0, 0, 'h00, 5, 1};
        tv[7]  = '{6, 0, 1, 2, 0, 0, 'h00, 4, 3};
        tv[8]  = '{6, 0, 0, 0, 0, 1, 'hA6, 3, 2};
        tv[9]  = '{6, 0, 0, 0, 0, 1, 'hA6, 3, 2};
        tv[10] = '{6, 0, 0, 0, 0, 1, 'hA6, 3, 2};
        tv[11] = '{6, 1, 1, 3, 0, 1, 'hA6, 3, 2};
        tv[12] = '{6, 1, 1, 4, 0, 1, 'hA7, 2, 6};
        tv[13] = '{6, 1, 1, 5, 0, 1, 'hA8, 1, 7};
        tv[14] = '{6, 1, 0, 0, 1, 1, 'hA9, 0, 5};
        tv[15] = '{6, 1, 0, 0, 1, 1, 'hAA, 0, 5};
        tv[16] = '{6, 1, 0, 0, 1, 0, 'h00, 0, 5};
        for (int i = 0; i < 16; i++) mem4[i] = 8'(8'hA5 + i);
        for (int i = 0; i < 4; i++) mem2[i] = '0;

        // reset held while the write pointers move
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wb4 = (i * 3 + 1) % 16;
            wb2 = i + 1;
            #1;
            chk("rst_rptr", rptr4, 0);
            chk("rst_rempty", rempty4, 1);
            chk("rst_ren", ren4, 0);
            chk("rst_valid", ov4, 0);
            chk("rst_rlevel", rl4, 0);
        end
        @(negedge clk);
        wb4 = 0;
        wb2 = 0;
        rst = 1'b1;

        // single word then back-pressure with five words
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            wb4 = tv[i].wb;
            rdy4 = tv[i].rdy[0];
            #1;
            chk($sformatf("v%0d_ren", i), ren4, tv[i].ren);
            if (tv[i].ren != 0) chk($sformatf("v%0d_raddr", i), raddr4, tv[i].raddr);
            chk($sformatf("v%0d_rempty", i), rempty4, tv[i].rempty);
            chk($sformatf("v%0d_valid", i), ov4, tv[i].ov);
            if (tv[i].ov != 0) chk($sformatf("v%0d_data", i), od4, tv[i].od);
            chk($sformatf("v%0d_rlevel", i), rl4, tv[i].rl);
            chk($sformatf("v%0d_rptr", i), rptr4, tv[i].rptr);
        end

        // asynchronous reset with a word queued and another in flight
        @(negedge clk);
        rdy4 = 1'b0;
        wb4 = 9;
        repeat (2) @(negedge clk);
        @(negedge clk);
        #1;
        chk("mid_pre_valid", ov4, 1);
        chk("mid_pre_data", od4, 'hAB);
        rst = 1'b0;
        #1;
        chk("mid_valid", ov4, 0);
        chk("mid_rptr", rptr4, 0);
        chk("mid_rlevel", rl4, 0);
        chk("mid_rempty", rempty4, 1);
        wb4 = 0;
        @(negedge clk);
        rst = 1'b1;
        rdy4 = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            chk("mid_no_stale", ov4, 0);
        end

        // wrap-around through the depth-4 RAM
        nren = 0;
        nbeat = 0;
        rdy2 = 1'b1;
        for (int cyc = 0; cyc < 80 && nbeat < 10; cyc++) begin
            @(negedge clk);
            #1;
            chk("wrap_rptr", rptr2, gray(nren % 8));
            if (wb2 < 10 && wb2 - nren < 4) begin
                mem2[wb2 % 4] = 8'(8'h30 + wb2);
                wb2++;
            end
            if (ren2) begin
                chk("wrap_raddr", raddr2, nren % 4);
                nren++;
            end
            if (ov2) begin
                chk("wrap_data", od2, 'h30 + nbeat);
                nbeat++;
            end
        end
        chk("wrap_beats", nbeat, 10);
        repeat (2) @(negedge clk);
        #1;
        chk("wrap_rempty", rempty2, 1);
        chk("wrap_rlevel", rl2, 0);
        chk("wrap_rptr_end", rptr2, gray(10 % 8));

        // burst: write pointer jumps by four in one edge
        @(negedge clk);
        rst = 1'b0;
        wb2 = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) mem2[k] = 8'(8'h50 + k);
        wb2 = 4;
        nren = 0;
        nbeat = 0;
        first_ren = 0;
        first_beat = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            #1;
            if (cyc == 0) begin
                chk("burst_rlevel", rl2, 4);
                chk("burst_rempty", rempty2, 0);
            end
            if (ren2) begin
                if (nren == 0) first_ren = cyc;
                chk("burst_ren_b2b", cyc, first_ren + nren);
                chk("burst_raddr", raddr2, nren);
                nren++;
            end
            if (ov2) begin
                if (nbeat == 0) first_beat = cyc;
                chk("burst_beat_b2b", cyc, first_beat + nbeat);
                chk("burst_data", od2, 'h50 + nbeat);
                nbeat++;
            end
        end
        chk("burst_rens", nren, 4);
        chk("burst_beats", nbeat, 4);
        chk("burst_latency", first_beat, first_ren + 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
